// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: Chans producer ports in, one registered consumer port out.
interface rr_mux_if #(
    parameter int Width = 8,
    parameter int Chans = 4,
    parameter int SelW  = 2
);
    logic [Width*Chans-1:0] in_data;
    logic [Chans-1:0]       in_valid;
    logic [Chans-1:0]       in_ready;
    logic [Width-1:0]       out;
    logic                   out_valid;
    logic                   out_ready;
    logic [SelW-1:0]        out_sel;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out, out_valid, out_sel
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out, out_valid, out_sel
    );
endinterface

// File: rtl/rr_mux.sv
// N-channel round-robin mux with a registered, backpressured output.
// Optional backpressure counter port: define RR_MUX_STALL_CNT_EN.
module rr_mux #(
    parameter int Width = 8,
    parameter int Chans = 4,
    parameter int SelW  = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    rr_mux_if.slave   bus
`ifdef RR_MUX_STALL_CNT_EN
    ,
    output logic [7:0] stall_cnt
`endif
);
    localparam logic [SelW:0]   ChansW = (SelW+1)'(Chans);
    localparam logic [SelW-1:0] LastCh = SelW'(Chans-1);

    logic [SelW-1:0]  ptr;
    logic [SelW-1:0]  win;
    logic [SelW-1:0]  sel_q;
    logic [SelW:0]    idx;
    logic             found;
    logic             load_en;
    logic             valid_q;
    logic [Width-1:0] data_q;
    logic [Chans-1:0] rdy;

    assign load_en = !valid_q || bus.out_ready;

    // Rotating search starting at ptr; one extra index bit absorbs the wrap
    // so a non-power-of-two Chans never aliases onto a missing channel.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < Chans; i++) begin
            idx = {1'b0, ptr} + (SelW+1)'(i);
            if (idx >= ChansW) idx = idx - ChansW;
            if (!found && bus.in_valid[idx[SelW-1:0]]) begin
                found = 1'b1;
                win   = idx[SelW-1:0];
            end
        end
    end

    always_comb begin
        rdy = '0;
        if (found && load_en && rst_n) rdy[win] = 1'b1;
    end

    assign bus.in_ready  = rdy;
    assign bus.out       = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_sel   = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= '0;
        end else if (load_en) begin
            if (found) begin
                data_q  <= bus.in_data[Width*int'(win) +: Width];
                sel_q   <= win;
                valid_q <= 1'b1;
                ptr     <= (win == LastCh) ? '0 : win + 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef RR_MUX_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (valid_q && !bus.out_ready && stall_cnt != 8'hFF)
            stall_cnt <= stall_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: directed scenarios plus random traffic against a round-robin model.
module tb_rr_mux;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_mux_if #(.Width(W), .Chans(CH), .SelW(SW)) bus ();
    rr_mux_if #(.Width(W), .Chans(3),  .SelW(SW)) bus3 ();

`ifdef RR_MUX_STALL_CNT_EN
    logic [7:0] stall_cnt;
    logic [7:0] stall_cnt3;
`endif

    rr_mux #(.Width(W), .Chans(CH), .SelW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef RR_MUX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    rr_mux #(.Width(W), .Chans(3), .SelW(SW)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
`ifdef RR_MUX_STALL_CNT_EN
        , .stall_cnt(stall_cnt3)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what the output port should hold, plus the priority pointer.
    int          m_ptr;
    int          m_sel;
    int          m_stall;
    bit          m_valid;
    logic [W-1:0] m_out;

    function automatic int arb(input logic [CH-1:0] v, input int p);
        for (int i = 0; i < CH; i++)
            if (v[(p + i) % CH]) return (p + i) % CH;
        return -1;
    endfunction

    function automatic logic [CH-1:0] exp_rdy();
        logic [CH-1:0] r;
        int g;
        r = '0;
        g = arb(bus.in_valid, m_ptr);
        if (g >= 0 && rst_n && (!m_valid || bus.out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_clear();
        m_ptr = 0; m_sel = 0; m_stall = 0; m_valid = 0; m_out = '0;
    endtask

    task automatic tick();
        int g, n_ptr, n_sel, n_stall;
        bit n_valid;
        logic [W-1:0] n_out;
        g = arb(bus.in_valid, m_ptr);
        n_ptr = m_ptr; n_sel = m_sel; n_valid = m_valid; n_out = m_out; n_stall = m_stall;
        if (m_valid && !bus.out_ready && m_stall < 255) n_stall = m_stall + 1;
        if (!m_valid || bus.out_ready) begin
            if (g >= 0) begin
                n_out = bus.in_data[g*W +: W];
                n_sel = g;
                n_valid = 1;
                n_ptr = (g + 1) % CH;
            end else begin
                n_valid = 0;
            end
        end
        @(posedge clk);
        m_ptr = n_ptr; m_sel = n_sel; m_valid = n_valid; m_out = n_out; m_stall = n_stall;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = '0; bus.out_ready = 1'b0;
        bus3.in_valid = '0; bus3.out_ready = 1'b0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = '1;
        bus.in_data = {$urandom(), $urandom()};
        bus.out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        if (bus.out !== 8'h00) begin errors++; $display("FAIL reset_out: got %0h expected 0", bus.out); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); end
        checks++;
        if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", bus.out_sel); end
        checks++;
        if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.in_ready); end
        checks++;
`ifdef RR_MUX_STALL_CNT_EN
        if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
        checks++;
`endif
        rst_n = 1'b1;
        #1;
        if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_ready: got %b expected 0001", bus.in_ready); end
        checks++;
        tick();
        if (bus.out_sel !== 2'd0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_first_grant: got sel %0d valid %0b expected sel 0 valid 1", bus.out_sel, bus.out_valid);
        end
        checks++;
    endtask

    task automatic test_single();
        do_reset();
        bus.in_data = {8'h33, 8'hA5, 8'h11, 8'h22};
        bus.in_valid = 4'b0100;
        bus.out_ready = 1'b1;
        #1;
        if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bus.in_ready); end
        checks++;
        tick();
        bus.in_valid = '0;
        if (bus.out !== 8'hA5 || bus.out_sel !== 2'd2 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL single_out: got out %0h sel %0d valid %0b expected a5 2 1", bus.out, bus.out_sel, bus.out_valid);
        end
        checks++;
        tick();
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got valid %0b expected 0", bus.out_valid); end
        checks++;
    endtask

    task automatic test_contention();
        do_reset();
        bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_sel !== SW'(i % 4) || bus.out !== 8'(8'h10 + i % 4)) begin
                errors++; $display("FAIL contention_%0d: got sel %0d out %0h expected sel %0d out %0h",
                                   i, bus.out_sel, bus.out, i % 4, 8'h10 + i % 4);
            end
            checks++;
        end
    endtask

    // Continues from contention: last grant was channel 1.
    task automatic test_wrap();
        bus.in_valid = 4'b1000;
        #1;
        if (bus.in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready3: got %b expected 1000", bus.in_ready); end
        checks++;
        tick();
        bus.in_valid = 4'b0010;
        #1;
        if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ready1: got %b expected 0010", bus.in_ready); end
        checks++;
        tick();
        if (bus.out_sel !== 2'd1) begin errors++; $display("FAIL wrap_sel1: got %0d expected 1", bus.out_sel); end
        checks++;
        bus.in_valid = 4'b1111;
        #1;
        if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ptr2: got %b expected 0100", bus.in_ready); end
        checks++;
        tick();
        // Three-channel instance: pointer must wrap from 2 to 0, never visit 3.
        bus3.in_data = {8'hC2, 8'hC1, 8'hC0};
        bus3.in_valid = 3'b111;
        bus3.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus3.out_sel !== SW'(i % 3) || bus3.out !== 8'(8'hC0 + i % 3)) begin
                errors++; $display("FAIL wrap3_%0d: got sel %0d out %0h expected sel %0d out %0h",
                                   i, bus3.out_sel, bus3.out, i % 3, 8'hC0 + i % 3);
            end
            checks++;
        end
        bus3.in_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        do_reset();
        bus.in_data = {$urandom(), $urandom()};
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        tick();
        held = bus.in_data[7:0];
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 0000", i, bus.in_ready); end
            checks++;
            tick();
            if (bus.out !== held || bus.out_sel !== 2'd0 || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold_%0d: got out %0h sel %0d valid %0b expected %0h 0 1",
                                   i, bus.out, bus.out_sel, bus.out_valid, held);
            end
            checks++;
        end
`ifdef RR_MUX_STALL_CNT_EN
        if (stall_cnt !== 8'd3) begin errors++; $display("FAIL bp_stall: got %0d expected 3", stall_cnt); end
        checks++;
`endif
        bus.out_ready = 1'b1;
        #1;
        if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", bus.in_ready); end
        checks++;
        tick();
        if (bus.out !== bus.in_data[15:8] || bus.out_sel !== 2'd1 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release_out: got out %0h sel %0d valid %0b expected %0h 1 1",
                               bus.out, bus.out_sel, bus.out_valid, bus.in_data[15:8]);
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = CH'($urandom);
            bus.in_data = {$urandom(), $urandom()};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_ready !== exp_rdy()) begin
                errors++; $display("FAIL rand_ready_%0d: got %b expected %b", i, bus.in_ready, exp_rdy());
            end
            checks++;
            tick();
            if (bus.out_valid !== m_valid || bus.out !== m_out || bus.out_sel !== SW'(m_sel)) begin
                errors++; $display("FAIL rand_out_%0d: got out %0h sel %0d valid %0b expected %0h %0d %0b",
                                   i, bus.out, bus.out_sel, bus.out_valid, m_out, m_sel, m_valid);
            end
            checks++;
`ifdef RR_MUX_STALL_CNT_EN
            if (stall_cnt !== 8'(m_stall)) begin errors++; $display("FAIL rand_stall_%0d: got %0d expected %0d", i, stall_cnt, m_stall); end
            checks++;
`endif
        end
    endtask

    task automatic test_async_reset();
        bus.in_valid = 4'b1111;
        bus.in_data = {$urandom(), $urandom()};
        bus.out_ready = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
            errors++; $display("FAIL async_reset: got valid %0b ready %b expected 0 0000", bus.out_valid, bus.in_ready);
        end
        checks++;
`ifdef RR_MUX_STALL_CNT_EN
        if (stall_cnt !== 8'd0) begin errors++; $display("FAIL async_stall: got %0d expected 0", stall_cnt); end
        checks++;
`endif
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

`ifdef RR_MUX_STALL_CNT_EN
    task automatic test_saturation();
        do_reset();
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        repeat (300) tick();
        if (stall_cnt !== 8'd255 || m_stall != 255) begin
            errors++; $display("FAIL stall_saturate: got %0d expected 255", stall_cnt);
        end
        checks++;
    endtask
`endif

    initial begin
        bus.in_data = '0; bus.in_valid = '0; bus.out_ready = 1'b0;
        bus3.in_data = '0; bus3.in_valid = '0; bus3.out_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_backpressure();
        test_random();
        test_async_reset();
`ifdef RR_MUX_STALL_CNT_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, W-bit round-robin multiplexer with a registered output and valid/ready handshakes on every port. It generalises the team's 2:1 variable-width mux:
- the select is computed internally by a fair arbiter;
- the result is held in an output register until the downstream consumer accepts it.

It sits between several producers and one shared datapath, for example a shared ALU or bus.

## Interface
Parameters:
- Width, 8, data bits per channel (≥1)
- Chans, 4, number of input channels (≥2)
- SelW, 2, channel-index width; 2^SelW ≥ Chans is required

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  Width*Chans  packed channel data; channel k occupies bits [k*Width +: Width]
- in_valid  input  Chans  per-channel request
- in_ready  output  Chans  per-channel accept (combinational, one-hot or zero)
- out  output  Width  registered selected data
- out_valid  output  1  out holds an unconsumed word
- out_ready  input  1  consumer accepts out
- out_sel  output  SelW  index of the channel whose data is in out
- stall_cnt  output  8  backpressure counter; present only when RR_MUX_STALL_CNT_EN is defined

## Operation
- Transfer rule: a transfer on a channel occurs when that channel's valid and ready are both 1 at a rising clk edge. The same rule applies on the output side.
- load_en = !out_valid | out_ready, i.e. the output register is empty or is being drained this cycle.
- Arbitration: a round-robin pointer ptr (SelW bits) gives the highest-priority channel. The winner g is the first channel with in_valid=1 found by searching ptr, ptr+1, …, Chans-1, 0, …, ptr-1.
- in_ready[g] = load_en & rst_n. All other in_ready bits are 0. If no channel is valid, in_ready = 0.
- On a load with a winner:
  - out ← in_data[g], out_sel ← g, out_valid ← 1.
  - ptr ← g+1, wrapping from Chans-1 to 0. This also applies when Chans is not a power of two.
- On a load with no winner: out_valid ← 0. out, out_sel and ptr hold.
- Without load_en (out_valid=1, out_ready=0): all registers hold and in_ready = 0.
- ptr only advances on a grant. An idle cycle does not change priority.
- Producers must hold in_valid and in_data stable until accepted. The block's correctness does not depend on this; a withdrawn request simply loses arbitration.
- Reset (async assert, synchronous release): out=0, out_valid=0, out_sel=0, ptr=0, stall_cnt=0, in_ready=0.
- Reset mid-stream: the held word is discarded. out_valid drops immediately, without waiting for clk.

## Timing
- Latency: a word accepted at edge n appears on out/out_valid after edge n (one cycle).
- Throughput: one word per cycle while out_ready=1, because load and drain occur on the same edge.
- in_ready depends combinationally on in_valid, out_valid, out_ready and ptr. There is no combinational path from in_data to any output.
- Fairness: with all channels continuously valid and out_ready=1, grants follow 0,1,…,Chans-1,0. Each channel waits at most Chans-1 grants.
- Simultaneous drain and load: the old word leaves and the new word enters on the same edge. out_valid stays 1.

## Configuration
- RR_MUX_STALL_CNT_EN defined:
  - The stall_cnt port and register exist.
  - stall_cnt increments on every edge where out_valid=1 and out_ready=0.
  - It saturates at 255 and never wraps.
  - It clears only on reset.
- RR_MUX_STALL_CNT_EN undefined: the port and register are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1 → out=0, out_valid=0, out_sel=0, in_ready=0000. After release, the first grant goes to channel 0.
- Single request: only in_valid[2]=1, in_data ch2=0xA5, out_ready=1 → in_ready=0100 in that cycle. Next cycle: out=0xA5, out_sel=2, out_valid=1. On the following idle cycle, out_valid=0.
- Full contention: in_valid=1111 for 6 cycles, channel k data=0x10+k, out_ready=1 → out_sel sequence 0,1,2,3,0,1 and out sequence 0x10,0x11,0x12,0x13,0x10,0x11 on consecutive cycles.
- Wrap: after a grant to channel 3 (ptr=0), only in_valid[1]=1 → grant 1, then ptr=2. Repeat with Chans=3: after a grant to 2, ptr=0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=1111 → out and out_sel stable, in_ready=0000, stall_cnt=3 (macro on). Raising out_ready drains the word and loads the next on the same edge.
- Async reset mid-stream: assert rst_n between clock edges while out_valid=1 → out_valid=0 and in_ready=0000 immediately. stall_cnt=0 (macro on).
